// File: rtl/btn_debounce_repeat.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and press/release/step pulses
// with optional auto-repeat while the button is held.
module btn_debounce_repeat #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic CLK,
  input  logic BTN_RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

  logic             s1_q;
  logic             s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             first_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             step_q;
  logic [CNT_W-1:0] rtarget_d;

  // Metastability guard; only s2_q is seen by the FSM.
  always_ff @(posedge CLK) begin
    if (BTN_RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // First repeat after a press waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rtarget_d = first_q ? RD_LAST : RP_LAST;

  always_ff @(posedge CLK) begin
    if (BTN_RST) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q <= ARM_PRESS;
            dcnt_q  <= '0;
          end
        end
        ARM_PRESS: begin
          if (!s2_q) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DB_LAST) begin
            state_q <= HELD;
            dcnt_q  <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            step_q  <= 1'b1;
            rcnt_q  <= '0;
            first_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2_q) begin
            // rcnt_q and first_q stay frozen so a release bounce keeps repeat phase.
            state_q <= ARM_RELEASE;
            dcnt_q  <= '0;
          end else if (REPEAT_EN) begin
            if (rcnt_q == rtarget_d) begin
              step_q  <= 1'b1;
              rcnt_q  <= '0;
              first_q <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q + CNT_W'(1);
            end
          end
        end
        ARM_RELEASE: begin
          if (s2_q) begin
            state_q <= HELD;
            dcnt_q  <= '0;
          end else if (dcnt_q == DB_LAST) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            first_q   <= 1'b0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          dcnt_q  <= '0;
          rcnt_q  <= '0;
          first_q <= 1'b0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 (and 0), REPEAT_PERIOD=3.
module tb_btn_debounce_repeat;

  logic CLK;
  logic BTN_RST;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, step_pulse;
  logic btn_level0, press_pulse0, release_pulse0, step_pulse0;

  int n_pass;
  int n_total;

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
  ) u_dut (
    .CLK(CLK), .BTN_RST(BTN_RST), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .step_pulse(step_pulse)
  );

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3), .CNT_W(8)
  ) u_dut0 (
    .CLK(CLK), .BTN_RST(BTN_RST), .btn_raw(btn_raw),
    .btn_level(btn_level0), .press_pulse(press_pulse0),
    .release_pulse(release_pulse0), .step_pulse(step_pulse0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs packed as {level, press, release, step}.
  function automatic logic [3:0] obs();
    return {btn_level, press_pulse, release_pulse, step_pulse};
  endfunction

  function automatic logic [3:0] obs0();
    return {btn_level0, press_pulse0, release_pulse0, step_pulse0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    btn_raw = 1'b0;
    BTN_RST = 1'b1;
    tick();
    tick();
    BTN_RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    btn_raw = 1'b1;
    BTN_RST = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_total++;
      if (obs() !== 4'b0000)
        $display("FAIL reset_hold c=%0d got=%b exp=%b", c, obs(), 4'b0000);
      else n_pass++;
    end
    BTN_RST = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {(e >= 7), (e == 7), 1'b0, (e == 7)};
      n_total++;
      if (obs() !== exp)
        $display("FAIL reset_exit e=%0d got=%b exp=%b", e, obs(), exp);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    apply_reset();
    btn_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp = {(e >= 7 && e < 27), (e == 7), (e == 27), (e == 7 || e == 17 || e == 20)};
      n_total++;
      if (obs() !== exp)
        $display("FAIL clean_press e=%0d got=%b exp=%b", e, obs(), exp);
      else n_pass++;
      if (e == 20) btn_raw = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [9:0] seq;
    seq = 10'b0111011011;  // applied LSB first: 1,1,0,1,1,0,1,1,1,0
    apply_reset();
    for (int e = 1; e <= 22; e++) begin
      btn_raw = (e <= 10) ? seq[e-1] : 1'b0;
      tick();
      n_total++;
      if (obs() !== 4'b0000)
        $display("FAIL bounce e=%0d got=%b exp=%b", e, obs(), 4'b0000);
      else n_pass++;
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] exp;
    apply_reset();
    btn_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp = {(e >= 7), (e == 7), 1'b0,
             (e == 7 || e == 20 || e == 23 || e == 26 || e == 29)};
      n_total++;
      if (obs() !== exp)
        $display("FAIL release_bounce e=%0d got=%b exp=%b", e, obs(), exp);
      else n_pass++;
      btn_raw = (e + 1 == 13 || e + 1 == 14) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_repeat_off();
    logic [3:0] exp;
    int steps;
    steps = 0;
    apply_reset();
    btn_raw = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (step_pulse0 === 1'b1) steps++;
      exp = {(e >= 7), (e == 7), 1'b0, (e == 7)};
      n_total++;
      if (obs0() !== exp)
        $display("FAIL repeat_off e=%0d got=%b exp=%b", e, obs0(), exp);
      else n_pass++;
    end
    n_total++;
    if (steps !== 1)
      $display("FAIL repeat_off_count got=%0d exp=%0d", steps, 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_arm();
    logic [3:0] exp;
    apply_reset();
    btn_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_total++;
      if (obs() !== 4'b0000)
        $display("FAIL mid_arm_pre e=%0d got=%b exp=%b", e, obs(), 4'b0000);
      else n_pass++;
    end
    BTN_RST = 1'b1;
    tick();
    n_total++;
    if (obs() !== 4'b0000)
      $display("FAIL mid_arm_rst got=%b exp=%b", obs(), 4'b0000);
    else n_pass++;
    BTN_RST = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      tick();
      exp = {(r >= 7), (r == 7), 1'b0, (r == 7)};
      n_total++;
      if (obs() !== exp)
        $display("FAIL mid_arm_post r=%0d got=%b exp=%b", r, obs(), exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    BTN_RST = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_repeat_off();
    test_reset_mid_arm();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
